// File: rtl/key_word_subrcon.sv
// Key-expansion word stage: substitutes the rotated column byte-by-byte through
// a shared external S-box, writes each substituted byte back to the column file,
// then folds in Rcon and w[i-4] to produce the next round-key word w[i].
// The Rcon sequence and the round counter live here.
module key_word_subrcon #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        start,
  input  logic [7:0]  col_b0,
  input  logic [7:0]  col_b1,
  input  logic [7:0]  col_b2,
  input  logic [7:0]  col_b3,
  input  logic [31:0] prev_w,
  output logic [7:0]  sbox_addr,
  input  logic [7:0]  sbox_data,
  output logic        wb_en,
  output logic [1:0]  wb_index,
  output logic [7:0]  wb_data,
  output logic [31:0] word_out,
  output logic        word_valid,
  output logic        busy,
  output logic        last_round
);

  localparam int CNT_W = $clog2(NUM_ROUNDS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_ROUNDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SUB  = 2'd1,
    S_XOR  = 2'd2
  } state_t;

  // GF(2^8) multiply-by-x, the step between successive Rcon values
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  state_t             state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic [7:0]         rcon_q, rcon_d;
  logic [CNT_W-1:0]   round_cnt_q, round_cnt_d;
  logic [3:0][7:0]    sub_q, sub_d;
  logic [31:0]        prev_q, prev_d;
  logic [31:0]        word_q, word_d;
  logic               word_valid_q, word_valid_d;
  logic [7:0]         col_sel;

  // Pick the column byte addressed by the current substitution index
  always_comb begin
    col_sel = col_b0;
    case (idx_q)
      2'd0:    col_sel = col_b0;
      2'd1:    col_sel = col_b1;
      2'd2:    col_sel = col_b2;
      2'd3:    col_sel = col_b3;
      default: col_sel = col_b0;
    endcase
  end

  // S-box lookup and write-back are combinational off the registered state so
  // an asynchronous reset drops wb_en and busy immediately
  assign sbox_addr  = col_sel;
  assign wb_en      = (state_q == S_SUB);
  assign wb_index   = idx_q;
  assign wb_data    = sbox_data;
  assign busy       = (state_q != S_IDLE);
  assign last_round = (round_cnt_q == LAST_CNT);
  assign word_out   = word_q;
  assign word_valid = word_valid_q;

  // Next-state logic: init has priority; start is only honoured from IDLE
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    rcon_d       = rcon_q;
    round_cnt_d  = round_cnt_q;
    sub_d        = sub_q;
    prev_d       = prev_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    if (init) begin
      state_d     = S_IDLE;
      idx_d       = 2'd0;
      rcon_d      = 8'h01;
      round_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            prev_d  = prev_w;
            idx_d   = 2'd0;
            state_d = S_SUB;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_SUB: begin
          sub_d[idx_q] = sbox_data;
          idx_d        = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = S_XOR;
          end else begin
            state_d = S_SUB;
          end
        end
        S_XOR: begin
          word_d       = {sub_q[0] ^ rcon_q, sub_q[1], sub_q[2], sub_q[3]} ^ prev_q;
          word_valid_d = 1'b1;
          rcon_d       = xtime(rcon_q);
          if (round_cnt_q == LAST_CNT) begin
            round_cnt_d = round_cnt_q;
          end else begin
            round_cnt_d = round_cnt_q + CNT_W'(1);
          end
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          idx_d   = 2'd0;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      idx_q        <= 2'd0;
      rcon_q       <= 8'h01;
      round_cnt_q  <= '0;
      sub_q        <= '0;
      prev_q       <= 32'h0000_0000;
      word_q       <= 32'h0000_0000;
      word_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      rcon_q       <= rcon_d;
      round_cnt_q  <= round_cnt_d;
      sub_q        <= sub_d;
      prev_q       <= prev_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
    end
  end

endmodule

// File: tb/tb_key_word_subrcon.sv
// Bench for key_word_subrcon: an AES S-box built from GF(2^8) inversion plus the
// affine map, a cycle-timeline model of one word operation, a per-cycle compare
// process, and directed FIPS-197 / Rcon / abort scenarios with literal checks.
module tb_key_word_subrcon;

  logic        clk;
  logic        rst;
  logic        init;
  logic        start;
  logic [7:0]  col_b0, col_b1, col_b2, col_b3;
  logic [31:0] prev_w;
  logic [7:0]  sbox_addr;
  logic [7:0]  sbox_data;
  logic        wb_en;
  logic [1:0]  wb_index;
  logic [7:0]  wb_data;
  logic [31:0] word_out;
  logic        word_valid;
  logic        busy;
  logic        last_round;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] sbox_tab [256];
  logic [9:0] wb_log [$];
  int         nvalid = 0;

  key_word_subrcon #(.NUM_ROUNDS(10)) dut (
    .clk(clk), .rst(rst), .init(init), .start(start),
    .col_b0(col_b0), .col_b1(col_b1), .col_b2(col_b2), .col_b3(col_b3),
    .prev_w(prev_w), .sbox_addr(sbox_addr), .sbox_data(sbox_data),
    .wb_en(wb_en), .wb_index(wb_index), .wb_data(wb_data),
    .word_out(word_out), .word_valid(word_valid), .busy(busy),
    .last_round(last_round)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign sbox_data = sbox_tab[sbox_addr];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1B) : {aa[6:0], 1'b0};
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    if (x != 8'h00) begin
      for (int y = 1; y < 256; y++) begin
        if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
      end
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  // Rcon for the n-th word of a schedule (n counted from 0)
  function automatic logic [7:0] rcon_of(input int n);
    case (n)
      0: return 8'h01;  1: return 8'h02;  2: return 8'h04;  3: return 8'h08;
      4: return 8'h10;  5: return 8'h20;  6: return 8'h40;  7: return 8'h80;
      8: return 8'h1B;  9: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // t_m = cycles since the accepting edge: 1..4 substitution, 5 combine, 6 result cycle
  int          t_m;
  int          round_m;
  logic [7:0]  col_m [4];
  logic [31:0] prev_m;
  logic [31:0] word_m;

  // Model advance on each clock edge, reset asynchronously like the design
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      t_m     <= 0;
      round_m <= 0;
      prev_m  <= 32'h0;
      word_m  <= 32'h0;
      for (int i = 0; i < 4; i++) col_m[i] <= 8'h00;
    end else if (init) begin
      t_m     <= 0;
      round_m <= 0;
    end else if ((t_m == 0 || t_m == 6) && start) begin
      t_m      <= 1;
      col_m[0] <= col_b0; col_m[1] <= col_b1; col_m[2] <= col_b2; col_m[3] <= col_b3;
      prev_m   <= prev_w;
    end else if (t_m >= 1 && t_m <= 5) begin
      t_m <= t_m + 1;
      if (t_m == 5) begin
        word_m  <= {sbox_tab[col_m[0]] ^ rcon_of(round_m), sbox_tab[col_m[1]],
                    sbox_tab[col_m[2]], sbox_tab[col_m[3]]} ^ prev_m;
        round_m <= (round_m < 10) ? round_m + 1 : 10;
      end
    end else begin
      t_m <= 0;
    end
  end

  // Per-cycle compare against the model, plus write-back / pulse logging
  initial begin
    forever begin
      @(negedge clk);
      if (wb_en === 1'b1) wb_log.push_back({wb_index, wb_data});
      if (word_valid === 1'b1) nvalid++;
      chk("busy", {31'd0, busy}, {31'd0, (t_m >= 1 && t_m <= 5)});
      chk("wb_en", {31'd0, wb_en}, {31'd0, (t_m >= 1 && t_m <= 4)});
      if (t_m >= 1 && t_m <= 4) begin
        chk("wb_index", {30'd0, wb_index}, 32'(t_m - 1));
        chk("sbox_addr", {24'd0, sbox_addr}, {24'd0, col_m[t_m-1]});
        chk("wb_data", {24'd0, wb_data}, {24'd0, sbox_tab[col_m[t_m-1]]});
      end else begin
        chk("sbox_addr_idle", {24'd0, sbox_addr}, {24'd0, col_b0});
      end
      chk("word_valid", {31'd0, word_valid}, {31'd0, (t_m == 6)});
      chk("word_out", word_out, word_m);
      chk("last_round", {31'd0, last_round}, {31'd0, (round_m == 10)});
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_col(input logic [7:0] c0, input logic [7:0] c1,
                         input logic [7:0] c2, input logic [7:0] c3,
                         input logic [31:0] pw);
    col_b0 = c0; col_b1 = c1; col_b2 = c2; col_b3 = c3; prev_w = pw;
  endtask

  // Run one isolated operation and stop in the result cycle
  task automatic run_op();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
  endtask

  logic [7:0] wb_exp [4];
  int nv0;

  initial begin
    for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_calc(8'(i));
    rst = 1'b0; init = 1'b0; start = 1'b0;
    set_col(8'h5A, 8'h00, 8'h00, 8'h00, 32'h0);
    tick(); tick();

    // pin the S-box model to known FIPS-197 entries
    chk("sbox_00", {24'd0, sbox_tab[8'h00]}, 32'h63);
    chk("sbox_cf", {24'd0, sbox_tab[8'hCF]}, 32'h8A);
    chk("sbox_6c", {24'd0, sbox_tab[8'h6C]}, 32'h50);

    // reset values
    chk("rst_word_out", word_out, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_wb_en", {31'd0, wb_en}, 32'd0);
    chk("rst_sbox_addr", {24'd0, sbox_addr}, 32'h5A);
    rst = 1'b1;
    tick();
    init = 1'b1; tick(); init = 1'b0;

    // FIPS-197 round 1
    wb_log.delete();
    set_col(8'hCF, 8'h4F, 8'h3C, 8'h09, 32'h2B7E1516);
    run_op();
    chk("r1_valid", {31'd0, word_valid}, 32'd1);
    chk("r1_word", word_out, 32'hA0FAFE17);
    wb_exp[0] = 8'h8A; wb_exp[1] = 8'h84; wb_exp[2] = 8'hEB; wb_exp[3] = 8'h01;
    chk("r1_wb_count", 32'(wb_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < wb_log.size(); i++)
      chk("r1_wb", {22'd0, wb_log[i]}, {22'd0, 2'(i), wb_exp[i]});
    tick();
    chk("r1_pulse_end", {31'd0, word_valid}, 32'd0);

    // FIPS-197 round 2
    wb_log.delete();
    set_col(8'h6C, 8'h76, 8'h05, 8'h2A, 32'hA0FAFE17);
    run_op();
    chk("r2_word", word_out, 32'hF2C295F2);
    wb_exp[0] = 8'h50; wb_exp[1] = 8'h38; wb_exp[2] = 8'h6B; wb_exp[3] = 8'hE5;
    chk("r2_wb_count", 32'(wb_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < wb_log.size(); i++)
      chk("r2_wb", {22'd0, wb_log[i]}, {22'd0, 2'(i), wb_exp[i]});
    tick();

    // Rcon walk: ten back-to-back words, start raised in each result cycle
    init = 1'b1; tick(); init = 1'b0;
    set_col(8'h00, 8'h00, 8'h00, 8'h00, 32'h0);
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      repeat (5) tick();
      chk("walk_valid", {31'd0, word_valid}, 32'd1);
      chk("walk_word", word_out, {8'h63 ^ rcon_of(k), 24'h636363});
      start = (k < 9);
      tick();
      start = 1'b0;
    end
    chk("walk_msb10", {24'd0, word_out[31:24]}, 32'h55);
    chk("walk_last_round", {31'd0, last_round}, 32'd1);
    init = 1'b1; tick(); init = 1'b0;
    chk("init_last_round", {31'd0, last_round}, 32'd0);
    chk("init_keeps_word", word_out, 32'h55636363);

    // start pulses during substitution and combine are ignored
    nv0 = nvalid;
    start = 1'b1; tick(); start = 1'b0;
    tick(); start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); start = 1'b1; tick(); start = 1'b0;
    repeat (8) tick();
    chk("one_valid_per_start", 32'(nvalid - nv0), 32'd1);

    // init in the second substitution cycle aborts the operation
    nv0 = nvalid;
    set_col(8'h11, 8'h22, 8'h33, 8'h44, 32'h12345678);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    init = 1'b1; tick(); init = 1'b0;
    chk("abort_idle", {31'd0, busy}, 32'd0);
    repeat (8) tick();
    chk("abort_no_valid", 32'(nvalid - nv0), 32'd0);
    set_col(8'h00, 8'h00, 8'h00, 8'h00, 32'h0);
    run_op();
    chk("abort_rcon01", word_out, 32'h62636363);
    tick();

    // asynchronous reset in the middle of substitution
    set_col(8'hAB, 8'hCD, 8'hEF, 8'h01, 32'hFFFFFFFF);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    #1 rst = 1'b0;
    #1;
    chk("arst_wb_en", {31'd0, wb_en}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_word_out", word_out, 32'h0);
    chk("arst_sbox_addr", {24'd0, sbox_addr}, 32'hAB);
    tick();
    rst = 1'b1;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
